// File: rtl/tpu_pkg.sv
// Shared constants and types for the TPU v2 MMIO controller.
//   - MMIO region bases for the A, B and C stores and the START/STATUS registers
//   - bit positions inside the STATUS word
//   - sequencer state encoding
package tpu_pkg;

    // MMIO region bases (byte addresses, 8-byte word granularity).
    localparam int unsigned A_BASE      = 32'h0100;
    localparam int unsigned B_BASE      = 32'h0200;
    localparam int unsigned C_BASE      = 32'h0300;
    localparam int unsigned START_ADDR  = 32'h0400;
    localparam int unsigned STATUS_ADDR = 32'h0500;

    // STATUS word layout.
    localparam int unsigned ST_BUSY    = 0;
    localparam int unsigned ST_DONE    = 1;
    localparam int unsigned ST_ERR     = 2;
    localparam int unsigned ST_ACC     = 3;
    localparam int unsigned ST_CYC_LSB = 8;
    localparam int unsigned ST_CYC_W   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2
    } tpu_state_e;

endpackage

// File: rtl/tpu_run_counter.sv
// Run-window counter and run-length statistics for the matmul sequencer.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : accepted START write; restarts both counters
//   busy       : sequencer is out of IDLE this cycle (feeds cycles)
//   en         : sequencer is in RUN this cycle (advances the window counter)
//   last       : final cycle of the RUNLEN-cycle window
//   cycles     : clocks spent out of IDLE since the last start, saturating
module tpu_run_counter #(
    parameter int unsigned RUNLEN = 22
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        busy,
    input  logic        en,
    output logic        last,
    output logic [15:0] cycles
);

    localparam int unsigned CNTW = (RUNLEN > 1) ? $clog2(RUNLEN) : 1;

    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [15:0]     cycles_q, cycles_d;

    assign last   = en && (cnt_q == CNTW'(RUNLEN - 1));
    assign cycles = cycles_q;

    always_comb begin
        cnt_d    = cnt_q;
        cycles_d = cycles_q;
        if (start) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = last ? '0 : cnt_q + 1'b1;
        end
        if (start) begin
            cycles_d = '0;
        end else if (busy && (cycles_q != 16'hFFFF)) begin
            cycles_d = cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            cycles_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
        end
    end

endmodule

// File: rtl/tpuv2_ctrl.sv
// MMIO front-end and matmul sequencer for the second-generation TPU.
//   clk, rst_n         : clock, asynchronous active-low reset
//   r_w, addr, dataIn  : host MMIO request (1 = write), byte address, write data
//   dataOut            : combinational read data (C words or STATUS, else 0)
//   a_wr_en, b_wr_en,
//   c_wr_en            : store write strobes, only while idle
//   row_idx, c_word    : decoded row / C word index of the current address
//   wr_data            : dataIn passthrough to the stores
//   c_rd_data          : C row selected by row_idx, from the array
//   c_clr              : one-cycle clear of all C accumulators (clear mode)
//   sa_en              : array/memA/memB advance enable for RUNLEN cycles
module tpuv2_ctrl
    import tpu_pkg::*;
#(
    parameter int unsigned BITS_AB = 8,
    parameter int unsigned BITS_C  = 16,
    parameter int unsigned DIM     = 8,
    parameter int unsigned ADDRW   = 16,
    parameter int unsigned DATAW   = 64,
    localparam int unsigned CWORDS = DIM * BITS_C / DATAW,
    localparam int unsigned RW     = $clog2(DIM),
    localparam int unsigned CWB    = $clog2(CWORDS),
    localparam int unsigned CWW    = (CWB > 0) ? CWB : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  r_w,
    input  logic [ADDRW-1:0]      addr,
    input  logic [DATAW-1:0]      dataIn,
    output logic [DATAW-1:0]      dataOut,
    output logic                  a_wr_en,
    output logic                  b_wr_en,
    output logic                  c_wr_en,
    output logic [RW-1:0]         row_idx,
    output logic [CWW-1:0]        c_word,
    output logic [DATAW-1:0]      wr_data,
    input  logic [DIM*BITS_C-1:0] c_rd_data,
    output logic                  c_clr,
    output logic                  sa_en
);

    localparam int unsigned RUNLEN = 3 * DIM - 2;
    localparam int unsigned CIW    = RW + CWB;

    // A/B row width equals DATAW by construction; kept only for documentation.
    localparam int unsigned unused_ab_row_bits = DIM * BITS_AB;

    localparam logic [ADDRW-1:0] A_A      = ADDRW'(A_BASE);
    localparam logic [ADDRW-1:0] B_A      = ADDRW'(B_BASE);
    localparam logic [ADDRW-1:0] C_A      = ADDRW'(C_BASE);
    localparam logic [ADDRW-1:0] START_A  = ADDRW'(START_ADDR);
    localparam logic [ADDRW-1:0] STATUS_A = ADDRW'(STATUS_ADDR);

    tpu_state_e state_q, state_d;
    logic       acc_q, acc_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic hit_a, hit_b, hit_c, hit_start, hit_status;
    logic busy, start_wr, run_last, wr_ok;
    logic [15:0]      cycles;
    logic [CIW-1:0]   c_idx;
    logic [RW-1:0]    c_row;
    logic [CWW-1:0]   c_wd;
    logic [DATAW-1:0] c_sel, status_word;
    logic             unused_addr;

    // Byte offset within a word carries no meaning.
    assign unused_addr = ^addr[2:0];

    // Region decode: index bits sit above the byte offset, the rest must match the base.
    assign hit_a      = addr[ADDRW-1:3+RW]  == A_A[ADDRW-1:3+RW];
    assign hit_b      = addr[ADDRW-1:3+RW]  == B_A[ADDRW-1:3+RW];
    assign hit_c      = addr[ADDRW-1:3+CIW] == C_A[ADDRW-1:3+CIW];
    assign hit_start  = addr[ADDRW-1:3]     == START_A[ADDRW-1:3];
    assign hit_status = addr[ADDRW-1:3]     == STATUS_A[ADDRW-1:3];

    assign c_idx = addr[3 +: CIW];

    generate
        if (CWORDS > 1) begin : g_cwords
            assign c_row = c_idx[CIW-1:CWB];
            assign c_wd  = c_idx[CWB-1:0];
        end else begin : g_cword1
            assign c_row = c_idx[RW-1:0];
            assign c_wd  = '0;
        end
    endgenerate

    assign busy     = (state_q != IDLE);
    assign start_wr = r_w && hit_start && (state_q == IDLE);
    // rst_n gates the strobes so the stores are never written while reset is held.
    assign wr_ok    = r_w && rst_n && (state_q == IDLE);

    assign a_wr_en = wr_ok && hit_a;
    assign b_wr_en = wr_ok && hit_b;
    assign c_wr_en = wr_ok && hit_c;
    assign wr_data = dataIn;

    // B rows are also reported on row_idx; the B store ignores it.
    always_comb begin
        row_idx = '0;
        c_word  = '0;
        if (hit_a || hit_b) begin
            row_idx = addr[3 +: RW];
        end else if (hit_c) begin
            row_idx = c_row;
            c_word  = c_wd;
        end
    end

    tpu_run_counter #(
        .RUNLEN (RUNLEN)
    ) u_run_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_wr),
        .busy   (busy),
        .en     (state_q == RUN),
        .last   (run_last),
        .cycles (cycles)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        done_d  = done_q;
        err_d   = err_q;
        c_clr   = 1'b0;
        sa_en   = 1'b0;

        if (r_w && hit_status) begin
            err_d = 1'b0;
        end
        // Store and START writes while a run is in flight are dropped and flagged.
        if (r_w && busy && (hit_a || hit_b || hit_c || hit_start)) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (start_wr) begin
                    acc_d   = dataIn[0];
                    done_d  = 1'b0;
                    state_d = dataIn[0] ? RUN : CLEAR;
                end
            end
            CLEAR: begin
                c_clr   = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                sa_en = 1'b1;
                if (run_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        status_word                         = '0;
        status_word[ST_BUSY]                = busy;
        status_word[ST_DONE]                = done_q;
        status_word[ST_ERR]                 = err_q;
        status_word[ST_ACC]                 = acc_q;
        status_word[ST_CYC_LSB +: ST_CYC_W] = cycles;
    end

    always_comb begin
        c_sel   = '0;
        dataOut = '0;
        for (int unsigned w = 0; w < CWORDS; w++) begin
            if (32'(c_word) == w) begin
                c_sel = c_rd_data[w*DATAW +: DATAW];
            end
        end
        if (!r_w) begin
            if (hit_c) begin
                dataOut = c_sel;
            end else if (hit_status) begin
                dataOut = status_word;
            end
        end
    end

endmodule
